// File: rtl/buzzer_pkg.sv
// Shared types and constants for the three-channel buzzer arbiter.
// Channel indices are also the bit positions in grant/pending.
package buzzer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam int NUM_CH = 3;
    localparam logic [1:0] CH1 = 2'd0;
    localparam logic [1:0] CH2 = 2'd1;
    localparam logic [1:0] CH3 = 2'd2;

    localparam int DEF_DEBOUNCE  = 4;
    localparam int DEF_BEEP_ON   = 5;
    localparam int DEF_BEEP_OFF  = 5;
    localparam int DEF_MIN_GRANT = 20;

    function automatic logic [1:0] next_ch(input logic [1:0] idx);
        return (idx == CH3) ? CH1 : idx + 2'd1;
    endfunction

    // First requesting channel at or after ptr, wrapping 1->2->3->1.
    function automatic logic [1:0] rr_pick(input logic [NUM_CH-1:0] req, input logic [1:0] ptr);
        logic [1:0] sel;
        int         c;
        sel = ptr;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            c = (int'(ptr) + i) % NUM_CH;
            if (req[c]) sel = 2'(c);
        end
        return sel;
    endfunction

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [1:0] idx);
        logic [NUM_CH-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    function automatic logic [1:0] oh_to_idx(input logic [NUM_CH-1:0] oh);
        if (oh[CH2]) return CH2;
        if (oh[CH3]) return CH3;
        return CH1;
    endfunction

endpackage

// File: rtl/buzzer_arbiter_sensor_debounce.sv
// Two-flop synchroniser followed by a symmetric debounce on one raw sensor line.
// The level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);
    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta <= raw;
            r_sync <= r_meta;
            if (r_sync != r_level) begin
                if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_level <= r_sync;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level = r_level;

endmodule

// File: rtl/buzzer_arbiter.sv
// Round-robin sharing of one alarm buzzer driver among three debounced sensors.
// Grants only change at the end of an OFF phase, so every beep completes.
module buzzer_arbiter
    import buzzer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
    parameter int BEEP_ON         = DEF_BEEP_ON,
    parameter int BEEP_OFF        = DEF_BEEP_OFF,
    parameter int MIN_GRANT       = DEF_MIN_GRANT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              sensor1,
    input  logic              sensor2,
    input  logic              sensor3,
    output logic              buzzer1,
    output logic              buzzer2,
    output logic              buzzer3,
    output logic [NUM_CH-1:0] grant,
    output logic              alarm_active,
    output logic [NUM_CH-1:0] pending
);
    localparam int PH_MAX = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int TMR_W  = $clog2(MIN_GRANT + 1);

    state_t            r_state;
    state_t            w_next;
    logic [NUM_CH-1:0] r_grant;
    logic [1:0]        r_rr;
    logic [PH_W-1:0]   r_phase;
    logic [TMR_W-1:0]  r_timer;
    logic [NUM_CH-1:0] w_pending;
    logic [NUM_CH-1:0] w_buzz;
    logic [1:0]        w_pick;
    logic              w_own;
    logic              w_others;
    logic              w_last_on;
    logic              w_last_off;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb1 (
        .clk(clk), .reset(reset), .raw(sensor1), .level(w_pending[CH1]));
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb2 (
        .clk(clk), .reset(reset), .raw(sensor2), .level(w_pending[CH2]));
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb3 (
        .clk(clk), .reset(reset), .raw(sensor3), .level(w_pending[CH3]));

    assign w_pick     = rr_pick(w_pending, r_rr);
    assign w_own      = |(w_pending & r_grant);
    assign w_others   = |(w_pending & ~r_grant);
    assign w_last_on  = (r_phase == PH_W'(BEEP_ON - 1));
    assign w_last_off = (r_phase == PH_W'(BEEP_OFF - 1));

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (!enable) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (|w_pending) w_next = ST_ON;
                ST_ON:   if (w_last_on) w_next = ST_OFF;
                ST_OFF: begin
                    if (w_last_off) begin
                        if (!w_own)                                          w_next = ST_GAP;
                        else if (r_timer >= TMR_W'(MIN_GRANT) && w_others)   w_next = ST_GAP;
                        else                                                 w_next = ST_ON;
                    end
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // r_timer counts grant cycles including the current one, so the decision
    // on the last OFF cycle of the second beep sees exactly MIN_GRANT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant <= '0;
            r_rr    <= CH1;
            r_phase <= '0;
            r_timer <= '0;
        end else if (!enable) begin
            r_grant <= '0;
            r_phase <= '0;
            r_timer <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_pending) begin
                        r_grant <= ch_onehot(w_pick);
                        r_phase <= '0;
                        r_timer <= TMR_W'(1);
                    end
                end
                ST_ON, ST_OFF: begin
                    if (r_timer < TMR_W'(MIN_GRANT)) r_timer <= r_timer + TMR_W'(1);
                    r_phase <= (w_next != r_state) ? '0 : r_phase + PH_W'(1);
                    if (w_next == ST_GAP) begin
                        r_grant <= '0;
                        r_rr    <= next_ch(oh_to_idx(r_grant));
                    end
                end
                default: begin
                    r_phase <= '0;
                    r_timer <= '0;
                end
            endcase
        end
    end

    always_comb begin
        w_buzz = '0;
        if (r_state == ST_ON) w_buzz = r_grant;
    end

    assign buzzer1      = w_buzz[CH1];
    assign buzzer2      = w_buzz[CH2];
    assign buzzer3      = w_buzz[CH3];
    assign grant        = r_grant;
    assign alarm_active = |r_grant;
    assign pending      = w_pending;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Directed bench for buzzer_arbiter: cycle n is the state after n rising edges
// following an input change; inputs are driven and outputs sampled on negedge.
module tb_buzzer_arbiter;

    logic       clk = 1'b0;
    logic       reset, enable, sensor1, sensor2, sensor3;
    logic       buzzer1, buzzer2, buzzer3, alarm_active;
    logic [2:0] grant, pending;
    logic [2:0] bz;
    logic [2:0] eg;
    int         checks = 0;
    int         errors = 0;

    buzzer_arbiter dut (
        .clk(clk), .reset(reset), .enable(enable),
        .sensor1(sensor1), .sensor2(sensor2), .sensor3(sensor3),
        .buzzer1(buzzer1), .buzzer2(buzzer2), .buzzer3(buzzer3),
        .grant(grant), .alarm_active(alarm_active), .pending(pending)
    );

    always #5 clk = ~clk;
    assign bz = {buzzer3, buzzer2, buzzer1};

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Beep pattern of a grant that started at cycle s: 5 on, 5 off.
    function automatic logic beep(input int n, input int s);
        return ((n - s) % 10) < 5;
    endfunction

    task automatic check_outs(input string tag, input int n, input logic [2:0] g);
        logic [2:0] b;
        b = g;
        check_eq($sformatf("%s grant n=%0d", tag, n), 32'(grant), 32'(g));
        check_eq($sformatf("%s alarm n=%0d", tag, n), 32'(alarm_active), 32'(|g));
        check_eq($sformatf("%s buzz n=%0d", tag, n), 32'(bz), 32'(b));
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1;
        sensor1 = 1'b1; sensor2 = 1'b1; sensor3 = 1'b1;
        @(negedge clk);

        // Reset held with all sensors high, then release.
        for (int n = 1; n <= 2; n++) begin
            tick();
            check_eq("rst all-zero", 32'({bz, grant, alarm_active, pending}), 32'd0);
        end
        reset = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            tick();
            if (n == 5) check_eq("A pending n=5", 32'(pending), 32'b000);
            if (n == 6) check_eq("A pending n=6", 32'(pending), 32'b111);
            if (n == 6) check_eq("A grant n=6", 32'(grant), 32'b000);
            if (n == 7) check_outs("A", n, 3'b001);
        end

        // Single sensor1: cadence, then release during the second ON cycle of beep 2.
        sensor1 = 1'b0; sensor2 = 1'b0; sensor3 = 1'b0;
        do_reset();
        sensor1 = 1'b1;
        for (int n = 1; n <= 28; n++) begin
            tick();
            if (n == 5)  check_eq("B pending n=5", 32'(pending), 32'b000);
            if (n == 6)  check_eq("B pending n=6", 32'(pending), 32'b001);
            if (n == 23) check_eq("B pending n=23", 32'(pending), 32'b001);
            if (n == 24) check_eq("B pending n=24", 32'(pending), 32'b000);
            if (n >= 7 && n <= 26) begin
                check_eq($sformatf("B grant n=%0d", n), 32'(grant), 32'b001);
                check_eq($sformatf("B buzz n=%0d", n), 32'(bz), 32'({2'b00, beep(n, 7)}));
            end
            if (n == 26) check_eq("B alarm n=26", 32'(alarm_active), 32'd1);
            if (n >= 27) check_outs("B", n, 3'b000);
            if (n == 18) sensor1 = 1'b0;
        end

        // 3-cycle glitch on sensor2 is filtered (pointer now at channel 2).
        sensor2 = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (n == 3) sensor2 = 1'b0;
            check_eq($sformatf("C quiet n=%0d", n), 32'({bz, grant, pending}), 32'd0);
        end

        // sensor2 and sensor3 together, pointer at channel 2: alternating grants.
        sensor2 = 1'b1; sensor3 = 1'b1;
        for (int n = 1; n <= 52; n++) begin
            tick();
            eg = 3'b000;
            if (n >= 7 && n <= 26)  eg = 3'b010;
            if (n >= 29 && n <= 48) eg = 3'b100;
            if (n >= 51)            eg = 3'b010;
            check_eq($sformatf("D grant n=%0d", n), 32'(grant), 32'(eg));
            if (n >= 7 && n <= 26)  check_eq($sformatf("D bz2 n=%0d", n), 32'(bz), 32'({1'b0, beep(n, 7), 1'b0}));
            if (n >= 29 && n <= 48) check_eq($sformatf("D bz3 n=%0d", n), 32'(bz), 32'({beep(n, 29), 2'b00}));
        end

        // sensor3 granted, enable dropped mid-ON, re-enabled; then reset mid-ON.
        sensor2 = 1'b0; sensor3 = 1'b0;
        do_reset();
        sensor3 = 1'b1;
        for (int n = 1; n <= 34; n++) begin
            tick();
            eg = 3'b000;
            if (n == 7 || n == 8)   eg = 3'b100;
            if (n >= 10 && n <= 29) eg = 3'b100;
            if (n >= 32)            eg = 3'b001;
            if (n <= 33) begin
                check_eq($sformatf("E grant n=%0d", n), 32'(grant), 32'(eg));
                check_eq($sformatf("E alarm n=%0d", n), 32'(alarm_active), 32'(|eg));
            end
            if (n == 7 || n == 8)   check_eq($sformatf("E bz n=%0d", n), 32'(bz), 32'b100);
            if (n == 9)             check_eq("E bz n=9", 32'(bz), 32'b000);
            if (n >= 10 && n <= 29) check_eq($sformatf("E bz n=%0d", n), 32'(bz), 32'({beep(n, 10), 2'b00}));
            if (n == 32 || n == 33) check_eq($sformatf("E bz n=%0d", n), 32'(bz), 32'b001);
            if (n == 34) check_eq("E reset all-zero", 32'({bz, grant, alarm_active, pending}), 32'd0);
            if (n == 8) enable = 1'b0;
            if (n == 9) begin
                enable  = 1'b1;
                sensor1 = 1'b1;
            end
            if (n == 33) reset = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/buzzer_arbiter.md
Name: buzzer_arbiter

Overview:
Shares one audible alarm driver among the three hazard sensors feeding the alarm state machine. Each sensor input is synchronised and debounced. Pending alarms are arbitrated round-robin, and the granted channel's buzzer is driven with a fixed on/off beep cadence. Each grant lasts a guaranteed minimum time, and grants change only at cadence boundaries, so no beep is ever truncated.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised cycles needed to accept a level change
BEEP_ON, 5, cycles the buzzer is high per beep
BEEP_OFF, 5, cycles the buzzer is low per beep
MIN_GRANT, 20, minimum cycles a grant is held before rotating to another requester

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  global alarm enable; low forces idle
sensor1  in  1  raw asynchronous sensor 1
sensor2  in  1  raw asynchronous sensor 2
sensor3  in  1  raw asynchronous sensor 3
buzzer1  out  1  cadence output, channel 1 (only while granted)
buzzer2  out  1  cadence output, channel 2
buzzer3  out  1  cadence output, channel 3
grant  out  3  one-hot current grant; bit0 = sensor1
alarm_active  out  1  high while any grant is held
pending  out  3  debounced request levels

Behaviour:
- Single clock domain (clk). Reset is synchronous, active-high, and has priority over everything.
- Reset values:
  - buzzer1..3 = 0, grant = 0, alarm_active = 0, pending = 0.
  - Synchronisers, debounce counters and timers cleared; FSM in IDLE.
  - Round-robin pointer = channel 1.
- Per-channel input path:
  - 2-flop synchroniser, then debounce.
  - The debounced level flips once the synchronised value has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing cycle resets the counter.
  - Rise latency = 2 + DEBOUNCE_CYCLES cycles (6 at defaults). Fall latency is the same.
  - pending mirrors the debounced levels.
- FSM states: IDLE, ON, OFF, GAP.
  - IDLE: if pending != 0, select the first pending channel at or after the RR pointer (order 1→2→3→1). Grant is registered and the state moves to ON on the next edge. The buzzer rises in the same cycle as grant.
  - ON: granted buzzerN = 1 for BEEP_ON cycles, then OFF.
  - OFF: buzzer = 0 for BEEP_OFF cycles. The last OFF cycle is the decision point, evaluated in this order:
    1. Own request dropped → GAP.
    2. grant_timer >= MIN_GRANT and another channel pending → GAP.
    3. Otherwise → ON (next beep).
  - GAP: one cycle with grant = 0, alarm_active = 0, all buzzers 0. The RR pointer advances to the channel after the one just released. Next state is IDLE.
- grant_timer:
  - Counts cycles since the grant started.
  - Saturates at MIN_GRANT.
  - Cleared on every new grant.
- A request dropping mid-ON or mid-OFF does not cut the current beep; the current ON+OFF phase completes before release.
- enable = 0: the next edge forces IDLE with grant and buzzers 0. Timers are cleared; the RR pointer and debounce state are kept.
- Reset asserted mid-grant: all outputs are 0 after that edge.
- Invariants:
  - Non-granted buzzers are always 0.
  - grant is always one-hot or zero.
  - Simultaneous new requests resolve strictly by the RR pointer.

Decomposition:
- Package buzzer_pkg:
  - FSM state enum (IDLE/ON/OFF/GAP).
  - Channel index constants CH1 = 0, CH2 = 1, CH3 = 2.
  - NUM_CH = 3.
  - Default timing constants.
- Sub-module sensor_debounce (synchroniser + debounce counter; DEBOUNCE_CYCLES parameter; ports clk, reset, raw, level), instantiated three times.
- Arbiter FSM, cadence timers and RR pointer live in buzzer_arbiter.

Test Plan:
- Reset held 2 cycles with all sensors high → all outputs 0 throughout. After release, pending = 3'b111 exactly 6 cycles later and grant = 3'b001 on the following cycle.
- Reset, then sensor1 held high from cycle 0 → pending[0] rises at cycle 6, grant = 001 at 7. buzzer1 high cycles 7–11, low 12–16, high 17–21. buzzer2 and buzzer3 stay 0.
- 3-cycle pulse on sensor2 (shorter than the debounce) → pending and grant stay 0, no buzzer activity.
- From idle with RR pointer = ch2, sensor2 and sensor3 rise in the same cycle → grant 010 for exactly MIN_GRANT = 20 cycles (two beeps), 1 GAP cycle, then 100 for 20 cycles, then 010 again. Alternation continues while both are held.
- sensor1 granted, sensor1 released during the second cycle of an ON phase → ON and OFF complete, then GAP. alarm_active falls at the cycle after the OFF phase ends.
- enable driven low mid-ON with sensor3 granted → grant = 0 and buzzer3 = 0 at the next edge. With enable high again (sensor3 still pending), a fresh grant starts with grant_timer reset; synchronous reset mid-ON gives the same all-zero result.
